// File: rtl/r200_pkg.sv
// r200_pkg: definitions shared by the r200 data-memory responder files.
//   - func3 width/extension codes for loads and stores (instruction bits [14:12])
//   - FSM state encoding used by r200dmem_resp
//   - width of the wait-state counter
package r200_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the 0..15 wait-state range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/r200dmem_lane.sv
// r200dmem_lane: combinational byte-lane steering for the data-memory responder.
// Ports:
//   func3     in   3  access width/extension code
//   addr_lo   in   2  byte offset within the word
//   rword     in  32  word currently held in storage
//   wdata     in  32  right-aligned store data
//   be        out  4  byte enables for a store
//   wword     out 32  store data replicated onto every lane (be picks the live ones)
//   rdata_ext out 32  selected and sign/zero-extended load data
//   misalign  out  1  half with addr_lo[0]=1, or word with addr_lo!=0
// Misaligned offsets are silently rounded down here: a half uses addr_lo[1]
// only and a word always uses lane 0. Whether that is an error is decided
// by the caller through the misalign flag.
module r200dmem_lane
    import r200_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be        = 4'b0000;
        wword     = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        case (func3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wword     = {4{wdata[7:0]}};
                rdata_ext = (func3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                            : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword     = {2{wdata[15:0]}};
                rdata_ext = (func3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                            : {16'h0, half_sel};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                be        = 4'b1111;
                wword     = wdata;
                rdata_ext = rword;
                misalign  = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/r200dmem_resp.sv
// r200dmem_resp: multi-cycle data-memory responder for the r200 MEM stage.
// Accepts one load/store at a time, waits WAIT_CYCLES, performs the access
// on the edge that enters RESP, and holds the response until rsp_ready.
// Parameters:
//   DEPTH_WORDS  storage size in 32-bit words (power of two)
//   WAIT_CYCLES  wait states between accept and response (0..15)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake (ready = FSM idle)
//   req_we, req_func3         store flag, width/extension code
//   req_addr, req_wdata       byte address, right-aligned store data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_err        extended load data (0 on stores/errors), fault flag
// Configuration macro: R200_DMEM_MISALIGN_ERR_EN -- when defined, misaligned
// half/word accesses fault instead of being rounded down to the aligned lane.
module r200dmem_resp
    import r200_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

`ifdef R200_DMEM_MISALIGN_ERR_EN
    localparam bit MISALIGN_ERR = 1'b1;
`else
    localparam bit MISALIGN_ERR = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       func3_q, func3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             acc_we;
    logic [2:0]       acc_func3;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             exec;
    logic             oor;
    logic             bad_f3;
    logic             acc_err;
    logic [AW-1:0]    idx;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wword;
    logic [31:0]      rdata_ext;
    logic             misalign;

    // With zero wait states the access executes on the accept edge, so it
    // must use the live request; otherwise it uses the holding registers.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_func3 = req_func3;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_func3 = func3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign oor   = |(acc_addr >> (AW + 2));
    assign idx   = acc_addr[AW+1:2];
    assign rword = mem[idx];

    always_comb begin
        bad_f3 = 1'b1;
        if (acc_we) begin
            case (acc_func3)
                F3_B, F3_H, F3_W: bad_f3 = 1'b0;
                default:          bad_f3 = 1'b1;
            endcase
        end else begin
            case (acc_func3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: bad_f3 = 1'b0;
                default:                        bad_f3 = 1'b1;
            endcase
        end
    end

    assign acc_err = oor | bad_f3 | (misalign & MISALIGN_ERR);

    r200dmem_lane u_lane (
        .func3     (acc_func3),
        .addr_lo   (acc_addr[1:0]),
        .rword     (rword),
        .wdata     (acc_wdata),
        .be        (be),
        .wword     (wword),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    func3_d = req_func3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        exec    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (exec) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'h0 : rdata_ext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        func3_q <= func3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // A store commits only on its execute edge; an asynchronous reset before
    // that edge returns the FSM to IDLE, so exec never fires for it.
    always_ff @(posedge clk) begin
        if (exec && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_r200dmem_resp.sv
module tb_r200dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        a_req_valid, b_req_valid;
    logic        a_req_ready, b_req_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        a_rsp_err, b_rsp_err;

    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign req_ready   = sel ? b_req_ready : a_req_ready;
    assign rsp_valid   = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata   = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err     = sel ? b_rsp_err   : a_rsp_err;

    r200dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (a_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (a_rsp_rdata),
        .rsp_err   (a_rsp_err)
    );

    r200dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_func3 (req_func3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (b_rsp_rdata),
        .rsp_err   (b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready held high; returns the response
    // and the number of edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
        @(negedge clk);
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_within_bound", 32'(lat < 40), 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] r;
        logic        e;
        int          l;
        xact(1'b1, f3, addr, wdata, r, e, l);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        int          l;
        xact(1'b0, f3, addr, 32'h0, r, e, l);
        chk(tag, r, exp);
        chk({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] r;
        logic        e;
        int          l;
        xact(we, f3, addr, wdata, r, e, l);
        chk({tag, "_err"}, 32'(e), 32'd1);
        chk({tag, "_rdata"}, r, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          l;

        rst       = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_func3 = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        #12;
        chk("reset_req_ready", 32'(a_req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("reset_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(a_rsp_err), 32'd0);
        chk("reset_w0_rsp_valid", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WAIT_CYCLES = 2: store, latency, then read back.
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, l);
        chk("sw_latency_w2", 32'(l), 32'd2);
        chk("sw_rdata", r, 32'h0);
        chk("sw_err", 32'(e), 32'd0);
        chk("idle_after_resp", 32'(req_ready), 32'd1);
        load_chk("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);

        // Byte lanes.
        store(3'b010, 32'h20, 32'h11223344);
        store(3'b000, 32'h22, 32'h000000AA);
        load_chk("lw_20", 3'b010, 32'h20, 32'h11AA3344);
        load_chk("lb_22", 3'b000, 32'h22, 32'hFFFFFFAA);
        load_chk("lbu_22", 3'b100, 32'h22, 32'h000000AA);
        load_chk("lbu_21", 3'b100, 32'h21, 32'h00000033);

        // Halves.
        store(3'b010, 32'h30, 32'h5555ABCD);
        store(3'b001, 32'h32, 32'h00008001);
        load_chk("lh_32", 3'b001, 32'h32, 32'hFFFF8001);
        load_chk("lhu_32", 3'b101, 32'h32, 32'h00008001);
        load_chk("lw_30", 3'b010, 32'h30, 32'h8001ABCD);
        load_chk("lh_30", 3'b001, 32'h30, 32'hFFFFABCD);

        // Errors: out of range, illegal load func3, illegal store func3.
        err_chk("lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0);
        err_chk("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0);
        err_chk("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        err_chk("sw_oor", 1'b1, 3'b010, 32'h1010, 32'h01234567);
        load_chk("lw_10_unchanged", 3'b010, 32'h10, 32'hDEADBEEF);

        // Misaligned accesses.
        store(3'b010, 32'h40, 32'hCAFEF00D);
`ifdef R200_DMEM_MISALIGN_ERR_EN
        err_chk("lw_41_misalign", 1'b0, 3'b010, 32'h41, 32'h0);
        err_chk("lh_43_misalign", 1'b0, 3'b001, 32'h43, 32'h0);
`else
        load_chk("lw_41", 3'b010, 32'h41, 32'hCAFEF00D);
        load_chk("lh_43", 3'b001, 32'h43, 32'hFFFFCAFE);
`endif

        // Reset during WAIT of a store drops it.
        store(3'b010, 32'h50, 32'h12345678);
        @(negedge clk);
        req_we    = 1'b1;
        req_func3 = 3'b010;
        req_addr  = 32'h50;
        req_wdata = 32'h99999999;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("midwait_in_wait", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_rsp_valid_held", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        load_chk("lw_50_prior", 3'b010, 32'h50, 32'h12345678);

        // WAIT_CYCLES = 0 instance: latency and backpressure.
        sel = 1'b1;
        xact(1'b1, 3'b010, 32'h60, 32'h01020304, r, e, l);
        chk("sw_latency_w0", 32'(l), 32'd0);
        @(negedge clk);
        req_we    = 1'b0;
        req_func3 = 3'b010;
        req_addr  = 32'h60;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rsp_valid_now", 32'(rsp_valid), 32'd1);
        chk("bp_rdata_now", rsp_rdata, 32'h01020304);
        // Different request on the inputs while stalled must be ignored.
        req_we    = 1'b1;
        req_addr  = 32'h60;
        req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h01020304);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("hs_cycle_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        load_chk("lw_60_unchanged", 3'b010, 32'h60, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
